// File: rtl/serial_pkg.sv
// rtl/serial_pkg.sv - shared types and line constants for the single-wire serial link
//
// Purpose : transmitter state encoding, line levels and a width helper, shared
//           by serial_tx, bit_timer and the future serial_rx.
// Ports   : none (package).

package serial_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    // Width needed to hold values 0..n-1, never less than one bit.
    function automatic int min1_clog2(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bit_timer.sv
// rtl/bit_timer.sv - bit-period counter producing a pulse on the last cycle of each line bit
//
// Purpose : counts 0..BIT_CYCLES-1 and wraps; tick marks the terminal count.
// Ports   : clk   - clock, rising edge
//           rstn  - synchronous active-low reset
//           clear - hold the counter at zero (used while the line is idle)
//           tick  - high during the last cycle of the current bit period

module bit_timer
    import serial_pkg::*;
#(
    parameter int BIT_CYCLES = 4
) (
    input  logic clk,
    input  logic rstn,
    input  logic clear,
    output logic tick
);

    localparam int            CW   = min1_clog2(BIT_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(BIT_CYCLES - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // With BIT_CYCLES == 1 the counter sits at zero and tick is permanently high.
    assign tick = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clear || tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/serial_tx.sv
// rtl/serial_tx.sv - framed single-bit serial transmitter (start, data LSB first, stop)
//
// Purpose : accepts a word over a valid/ready handshake and shifts it onto tx,
//           each line bit held BIT_CYCLES clocks.
// Option  : define SERIAL_TX_PARITY_EN to insert an even-parity bit after the data.
// Ports   : clk        - clock, rising edge
//           rstn       - synchronous active-low reset
//           in_valid   - in_data holds a word to send
//           in_ready   - high only in IDLE
//           in_data    - payload, sampled on the handshake edge only
//           tx         - registered serial line, idles high
//           busy       - frame in progress
//           frame_done - one-cycle pulse after the last stop-bit cycle

module serial_tx
    import serial_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int BIT_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              tx,
    output logic              busy,
    output logic              frame_done
);

    localparam int            IW       = min1_clog2(DATA_W + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(DATA_W - 1);

    tx_state_t         state_q;
    logic [DATA_W-1:0] shreg_q;
    logic [IW-1:0]     idx_q;
    logic              tx_q;
    logic              ready_q;
    logic              busy_q;
    logic              done_q;
    logic              tick;
`ifdef SERIAL_TX_PARITY_EN
    logic              parity_q;
`endif

    // Holding the timer clear in IDLE makes the start bit begin a full period
    // on the handshake edge.
    bit_timer #(
        .BIT_CYCLES(BIT_CYCLES)
    ) u_bit_timer (
        .clk  (clk),
        .rstn (rstn),
        .clear(state_q == IDLE),
        .tick (tick)
    );

    assign tx         = tx_q;
    assign in_ready   = ready_q;
    assign busy       = busy_q;
    assign frame_done = done_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q  <= IDLE;
            shreg_q  <= '0;
            idx_q    <= '0;
            tx_q     <= LINE_IDLE;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (in_valid && ready_q) begin
                        shreg_q  <= in_data;
`ifdef SERIAL_TX_PARITY_EN
                        parity_q <= ^in_data;
`endif
                        tx_q     <= START_BIT;
                        ready_q  <= 1'b0;
                        busy_q   <= 1'b1;
                        state_q  <= START;
                    end
                end
                START: begin
                    // Present bit 0 and pre-shift so shreg_q[0] is always the next bit.
                    if (tick) begin
                        tx_q    <= shreg_q[0];
                        shreg_q <= shreg_q >> 1;
                        idx_q   <= '0;
                        state_q <= DATA;
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (idx_q == LAST_IDX) begin
`ifdef SERIAL_TX_PARITY_EN
                            tx_q    <= parity_q;
                            state_q <= PARITY;
`else
                            tx_q    <= STOP_BIT;
                            state_q <= STOP;
`endif
                        end else begin
                            tx_q    <= shreg_q[0];
                            shreg_q <= shreg_q >> 1;
                            idx_q   <= idx_q + 1'b1;
                        end
                    end
                end
`ifdef SERIAL_TX_PARITY_EN
                PARITY: begin
                    if (tick) begin
                        tx_q    <= STOP_BIT;
                        state_q <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (tick) begin
                        tx_q    <= LINE_IDLE;
                        done_q  <= 1'b1;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    tx_q    <= LINE_IDLE;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_tx.sv
// tb/tb_serial_tx.sv - scoreboard bench for serial_tx (frames, back-to-back, busy, reset abort, parity)
//
// Purpose : directed frames with hand-written line patterns; a monitor checks
//           every cycle of every frame and of the idle line.
// Ports   : none (top-level bench).

module tb_serial_tx;

`ifdef SERIAL_TX_PARITY_EN
    localparam int BC = 1;
    localparam int NB = 11;
    // {stop, parity, data, start}; line bit i is bit i of the vector
    localparam logic [10:0] F_A5 = 11'b1_0_10100101_0;
    localparam logic [10:0] F_00 = 11'b1_0_00000000_0;
    localparam logic [10:0] F_FF = 11'b1_0_11111111_0;
    localparam logic [10:0] F_81 = 11'b1_0_10000001_0;
    localparam logic [10:0] F_3C = 11'b1_0_00111100_0;
    localparam logic [10:0] F_C3 = 11'b1_0_11000011_0;
    localparam logic [10:0] F_07 = 11'b1_1_00000111_0;
`else
    localparam int BC = 4;
    localparam int NB = 10;
    // {stop, data, start}
    localparam logic [10:0] F_A5 = 11'b0_1_10100101_0;
    localparam logic [10:0] F_00 = 11'b0_1_00000000_0;
    localparam logic [10:0] F_FF = 11'b0_1_11111111_0;
    localparam logic [10:0] F_81 = 11'b0_1_10000001_0;
    localparam logic [10:0] F_3C = 11'b0_1_00111100_0;
    localparam logic [10:0] F_C3 = 11'b0_1_11000011_0;
`endif
    localparam int FLEN = NB * BC;

    logic       clk = 1'b0;
    logic       rstn;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       tx;
    logic       busy;
    logic       frame_done;

    serial_tx #(
        .DATA_W    (8),
        .BIT_CYCLES(BC)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .tx        (tx),
        .busy      (busy),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [10:0] bits;
        int          gap;    // required start-to-start distance from previous frame, 0 = don't care
        bit          abort;  // frame is expected to be cut by a reset
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    bit   mon_active = 1'b0;
    int   mon_fcyc   = 0;
    int   mon_now    = 0;
    int   last_start = 0;
    exp_t cur;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Monitor: samples on the falling edge, walks the expected frame cycle by cycle.
    initial begin : monitor
        @(posedge clk);
        forever begin
            @(negedge clk);
            mon_now++;
            if (mon_active) begin
                if (mon_fcyc < FLEN) begin
                    chk("tx_bit",     32'(tx),         32'(cur.bits[mon_fcyc / BC]));
                    chk("busy_frame", 32'(busy),       32'd1);
                    chk("ready_busy", 32'(in_ready),   32'd0);
                    chk("done_early", 32'(frame_done), 32'd0);
                    if (!rstn) begin
                        chk("abort_planned", 32'(cur.abort), 32'd1);
                        mon_active = 1'b0;
                    end
                    mon_fcyc++;
                end else begin
                    chk("frame_done", 32'(frame_done), 32'd1);
                    chk("tx_end",     32'(tx),         32'd1);
                    chk("busy_end",   32'(busy),       32'd0);
                    chk("ready_end",  32'(in_ready),   32'd1);
                    chk("abort_missing", 32'(cur.abort), 32'd0);
                    mon_active = 1'b0;
                end
            end else begin
                chk("tx_idle",    32'(tx),         32'd1);
                chk("busy_idle",  32'(busy),       32'd0);
                chk("ready_idle", 32'(in_ready),   32'd1);
                chk("done_idle",  32'(frame_done), 32'd0);
            end
            // A handshake seen here happens on the next rising edge.
            if (!mon_active && rstn && in_valid && in_ready) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_handshake: got handshake, expected none (t=%0t)", $time);
                end else begin
                    cur = sb.pop_front();
                    if (cur.gap > 0) begin
                        chk("frame_gap", 32'(mon_now + 1 - last_start), 32'(cur.gap));
                    end
                    last_start = mon_now + 1;
                    mon_fcyc   = 0;
                    mon_active = 1'b1;
                end
            end
        end
    end

    task automatic send(input logic [7:0] d, input logic [10:0] bits, input int gap,
                        input bit abort, input bit keep);
        exp_t e;
        int   k;
        e.bits  = bits;
        e.gap   = gap;
        e.abort = abort;
        sb.push_back(e);
        in_valid = 1'b1;
        in_data  = d;
        for (k = 0; k < 500; k++) begin
            @(negedge clk);
            if (in_ready && rstn) break;
        end
        if (k == 500) begin
            n_cmp++;
            n_err++;
            $display("FAIL handshake_timeout: got in_ready=0, expected 1 within 500 cycles");
        end
        @(posedge clk);
        #1;
        if (!keep) in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin : stimulus
        rstn     = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        idle(20);

        send(8'hA5, F_A5, 0, 1'b0, 1'b0);
        idle(FLEN + 4);

        send(8'h00, F_00, 0, 1'b0, 1'b1);
        send(8'hFF, F_FF, FLEN + 1, 1'b0, 1'b0);
        idle(FLEN + 4);

        send(8'h81, F_81, 0, 1'b0, 1'b0);
        idle(3 * BC);
        in_valid = 1'b1;
        in_data  = 8'h7E;
        idle(3 * BC);
        in_data  = 8'h3C;
        send(8'h3C, F_3C, FLEN + 1, 1'b0, 1'b0);
        idle(FLEN + 4);

        send(8'hC3, F_C3, 0, 1'b1, 1'b0);
        idle(4 * BC);
        rstn = 1'b0;
        idle(1);
        rstn = 1'b1;
        idle(10);

`ifdef SERIAL_TX_PARITY_EN
        send(8'h07, F_07, 0, 1'b0, 1'b0);
        idle(FLEN + 4);
`endif

        for (int k = 0; k < 1000 && (sb.size() != 0 || mon_active); k++) begin
            @(posedge clk);
        end
        if (sb.size() != 0 || mon_active) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain: got %0d frames pending, expected 0", sb.size());
        end
        idle(4);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/serial_tx.md
Name: serial_tx

Overview:
Single-bit serial transmitter: accepts a parallel word through a valid/ready handshake and drives it onto a one-bit line as a framed bit stream: start bit, data LSB first, stop bit. It is the sending end of the single-wire link. A flop-based receiver (`dff` sampling on `d`) sits at the far end of this line. Used as the stimulus source for, and companion to, the team's serial receive and flop blocks.

Parameters:
- `DATA_W`, 8, payload bits per frame (1..32).
- `BIT_CYCLES`, 4, `clk` cycles each line bit is held (>=1; 1 legal).

Ports:
- `clk`  input  1  system clock; all state updates on the rising edge.
- `rstn`  input  1  synchronous active-low reset, sampled on the `clk` rising edge.
- `in_valid`  input  1  `in_data` holds a word to send.
- `in_ready`  output  1  block can accept a word this cycle.
- `in_data`  input  `DATA_W`  payload word; sampled only on handshake.
- `tx`  output  1  serial line; idle level 1; registered output.
- `busy`  output  1  frame in progress (any state other than IDLE).
- `frame_done`  output  1  one-cycle pulse after the last stop-bit cycle.

Behaviour:
- Reset (`rstn`=0 at an edge):
  - `tx`=1, `in_ready`=1, `busy`=0, `frame_done`=0.
  - State is IDLE; shift register, bit-period counter and bit index are cleared.
  - Reset mid-frame aborts the frame; `tx` returns to 1 on that same edge and the word is dropped.
- States: IDLE -> START -> DATA -> STOP -> IDLE (PARITY inserted between DATA and STOP when the optional feature is on).
- Handshake:
  - Transfer occurs on an edge where `in_valid`=1 and `in_ready`=1.
  - `in_ready`=1 only in IDLE.
  - `in_valid` is ignored while busy; `in_data` is not required to be stable outside the handshake edge.
- On the transfer edge:
  - `in_data` is captured into the shift register and the state goes to START.
  - `tx`=0 from that edge, so the start bit appears 1 cycle after the handshake cycle.
  - `in_ready`=0 and `busy`=1 from that edge.
- Bit timing:
  - Each line bit is held exactly `BIT_CYCLES` cycles.
  - The period counter counts 0..`BIT_CYCLES`-1; on the terminal count it advances to the next bit and reloads 0.
  - Counter width is max(1, clog2(`BIT_CYCLES`)).
- DATA:
  - `tx` = `shreg[0]`; the shift register shifts right by one at each bit boundary.
  - After `DATA_W` bits the state goes to STOP.
  - Bit index width is max(1, clog2(`DATA_W`+1)).
- STOP:
  - `tx`=1 for `BIT_CYCLES` cycles.
  - On the terminal count: state goes to IDLE, `frame_done`=1 for exactly one cycle, `in_ready`=1 and `busy`=0 from that edge.
- Frame length: (`DATA_W`+2)×`BIT_CYCLES` cycles of non-idle line time.
- Back-to-back:
  - A new handshake is possible in the first IDLE cycle.
  - The minimum inter-frame gap is therefore 0 idle-bit periods: a stop bit is immediately followed by the next start bit one cycle later.
  - The line holds `tx`=1 during that cycle.
- `in_valid` held high continuously produces a frame every (`DATA_W`+2)×`BIT_CYCLES`+1 cycles.

Optional Feature:
- Macro: `SERIAL_TX_PARITY_EN`.
- Defined:
  - A PARITY state follows DATA and lasts `BIT_CYCLES` cycles.
  - `tx` = even parity (XOR of the captured `DATA_W` bits), computed at capture.
  - Frame becomes (`DATA_W`+3)×`BIT_CYCLES` cycles.
- Undefined: no PARITY state, no parity register; DATA goes directly to STOP.

Decomposition:
- Package `serial_pkg` holds:
  - state typedef `tx_state_t` (IDLE, START, DATA, PARITY, STOP);
  - constants `LINE_IDLE`=1, `START_BIT`=0, `STOP_BIT`=1.
- `serial_rx` (future) shares this package.
- One natural sub-module: `bit_timer`.
  - Parameterized by `BIT_CYCLES`; inputs `clk`, `rstn`, `clear`.
  - Output `tick` pulses on the terminal count.
- The FSM, shift register and bit index stay in `serial_tx`.

Test Plan:
1. Reset then idle: hold `rstn`=0 for 2 cycles, release, `in_valid`=0 for 20 cycles -> `tx`=1, `in_ready`=1, `busy`=0 throughout.
2. Single frame: `DATA_W`=8, `BIT_CYCLES`=4, send 8'hA5 -> line bits 0,1,0,1,0,0,1,0,1,1, each held 4 cycles. The start bit begins 1 cycle after the handshake; `frame_done` pulses once at cycle 40 after the handshake.
3. Back-to-back: `in_valid` held high with words 8'h00 then 8'hFF -> the second handshake occurs in the first IDLE cycle; the frames are 41 cycles apart; the line shows one extra idle-high cycle between them.
4. Busy ignore: assert `in_valid` with 8'h3C mid-frame of 8'h81 -> 8'h3C is not accepted until `in_ready`=1. The transmitted bits of 8'h81 are unaffected by `in_data` changes.
5. Reset mid-frame: pull `rstn`=0 for 1 cycle during DATA bit 3 -> `tx`=1, `busy`=0, `in_ready`=1 on that edge; no `frame_done` pulse.
6. Parity (`SERIAL_TX_PARITY_EN`, `BIT_CYCLES`=1): send 8'h07 -> line 0,1,1,1,0,0,0,0,0,1,1 (parity=1); `frame_done` 11 cycles after the handshake.
